// File: rtl/sfu_ctrl_pkg.sv
// Shared types and widths for the SFU sequencer: FSM state encoding,
// latched job configuration and address/counter widths.
package sfu_ctrl_pkg;

    localparam int ADDR_W = 11;
    localparam int ROW_W  = 4;
    localparam int PASS_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_DRAIN,
        S_RELU,
        S_WB,
        S_CLR,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [PASS_W-1:0] num_pass;
        logic [ROW_W-1:0]  num_row;
        logic              relu_en;
    } job_cfg_t;

endpackage

// File: rtl/sfu_ctrl_addr_gen.sv
// Pass/row counters and the running psum read pointer. The pointer starts a
// row at its row index and advances by num_row per pass, so no multiplier.
module sfu_ctrl_addr_gen
    import sfu_ctrl_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic              i_step,
    input  logic              i_next_row,
    input  logic [PASS_W-1:0] i_num_pass,
    input  logic [ROW_W-1:0]  i_num_row,
    output logic [ROW_W-1:0]  o_row,
    output logic [ADDR_W-1:0] o_ptr,
    output logic              o_last_pass,
    output logic              o_last_row
);

    logic [PASS_W-1:0] r_pass;
    logic [ROW_W-1:0]  r_row;
    logic [ADDR_W-1:0] r_ptr;
    logic [ROW_W-1:0]  w_row_inc;

    assign w_row_inc = r_row + ROW_W'(1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pass <= '0;
            r_row  <= '0;
            r_ptr  <= '0;
        end else if (i_load) begin
            r_pass <= '0;
            r_row  <= '0;
            r_ptr  <= '0;
        end else if (i_next_row) begin
            r_pass <= '0;
            r_row  <= w_row_inc;
            r_ptr  <= ADDR_W'(w_row_inc);
        end else if (i_step) begin
            r_pass <= r_pass + PASS_W'(1);
            r_ptr  <= r_ptr + ADDR_W'(i_num_row);
        end
    end

    assign o_row       = r_row;
    assign o_ptr       = r_ptr;
    assign o_last_pass = (r_pass == i_num_pass - PASS_W'(1));
    assign o_last_row  = (r_row == i_num_row - ROW_W'(1));

endmodule

// File: rtl/sfu_ctrl.sv
// Sequencer for the SFU array: reads psums pass by pass, strobes the SFUs and
// writes finished rows. Optional feature macro: SFU_CTRL_PERF_EN (o_cycle_cnt).
module sfu_ctrl
    import sfu_ctrl_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [PASS_W-1:0] i_num_pass,
    input  logic [ROW_W-1:0]  i_num_row,
    input  logic              i_relu_en,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pmem_rd,
    output logic [ADDR_W-1:0] o_pmem_addr,
    output logic              o_sfu_acc,
    output logic              o_sfu_relu,
    output logic              o_sfu_clr,
    output logic              o_omem_wr,
    output logic [ROW_W-1:0]  o_omem_addr
`ifdef SFU_CTRL_PERF_EN
    ,
    output logic [31:0]       o_cycle_cnt
`endif
);

    state_t   r_state;
    state_t   w_next_state;
    job_cfg_t r_cfg;
    logic     r_sfu_acc;

    logic w_accept;
    logic w_empty_job;
    logic w_last_pass;
    logic w_last_row;
    logic w_busy;
    logic w_done;
    logic w_pmem_rd;
    logic w_sfu_relu;
    logic w_sfu_clr;
    logic w_omem_wr;
    logic [ROW_W-1:0]  w_row;
    logic [ADDR_W-1:0] w_ptr;

    assign w_accept    = (r_state == S_IDLE) && i_start;
    assign w_empty_job = (i_num_pass == '0) || (i_num_row == '0);

    // Config is only captured on an accepted start; later starts cannot disturb it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cfg <= '0;
        end else if (w_accept) begin
            r_cfg <= '{num_pass: i_num_pass, num_row: i_num_row, relu_en: i_relu_en};
        end
    end

    sfu_ctrl_addr_gen u_addr_gen (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_load      (w_accept),
        .i_step      (w_pmem_rd),
        .i_next_row  (w_sfu_clr),
        .i_num_pass  (r_cfg.num_pass),
        .i_num_row   (r_cfg.num_row),
        .o_row       (w_row),
        .o_ptr       (w_ptr),
        .o_last_pass (w_last_pass),
        .o_last_row  (w_last_row)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next_state = w_empty_job ? S_DONE : S_ACC;
            S_ACC:   if (w_last_pass) w_next_state = S_DRAIN;
            S_DRAIN: w_next_state = r_cfg.relu_en ? S_RELU : S_WB;
            S_RELU:  w_next_state = S_WB;
            S_WB:    w_next_state = S_CLR;
            S_CLR:   w_next_state = w_last_row ? S_DONE : S_ACC;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy     = (r_state != S_IDLE);
        w_done     = 1'b0;
        w_pmem_rd  = 1'b0;
        w_sfu_relu = 1'b0;
        w_sfu_clr  = 1'b0;
        w_omem_wr  = 1'b0;
        case (r_state)
            S_ACC:   w_pmem_rd  = 1'b1;
            S_RELU:  w_sfu_relu = 1'b1;
            S_WB:    w_omem_wr  = 1'b1;
            S_CLR:   w_sfu_clr  = 1'b1;
            S_DONE:  w_done     = 1'b1;
            default: ;
        endcase
    end

    // Accumulate lags the read by the one-cycle psum SRAM latency.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sfu_acc <= 1'b0;
        end else begin
            r_sfu_acc <= w_pmem_rd;
        end
    end

    assign o_busy      = w_busy;
    assign o_done      = w_done;
    assign o_pmem_rd   = w_pmem_rd;
    assign o_pmem_addr = w_ptr;
    assign o_sfu_acc   = r_sfu_acc;
    assign o_sfu_relu  = w_sfu_relu;
    assign o_sfu_clr   = w_sfu_clr;
    assign o_omem_wr   = w_omem_wr;
    assign o_omem_addr = w_row;

`ifdef SFU_CTRL_PERF_EN
    logic [31:0] r_cycle_cnt;

    // The DONE cycle closes the job, so the count is final and stable from there on.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cycle_cnt <= '0;
        end else if (w_accept) begin
            r_cycle_cnt <= '0;
        end else if (w_busy && !w_done && (r_cycle_cnt != 32'hFFFF_FFFF)) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
    end

    assign o_cycle_cnt = r_cycle_cnt;
`endif

endmodule
